// File: rtl/stream_mux_rr.sv
// CH-to-1 stream multiplexer with a registered output stage, fixed-select or round-robin arbitration.
// Optional per-channel accepted-transfer counters are enabled by defining STREAM_MUX_GRANT_CNT_EN.
module stream_mux_rr #(
    parameter int WIDTH = 4,
    parameter int CH    = 4,
    parameter int SEL_W = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [CH*WIDTH-1:0]   din,
    input  logic [CH-1:0]         din_valid,
    output logic [CH-1:0]         din_ready,
    input  logic                  mode,
    input  logic [SEL_W-1:0]      sel,
    output logic [WIDTH-1:0]      dout,
    output logic                  dout_valid,
    output logic [SEL_W-1:0]      dout_ch,
    input  logic                  dout_ready
`ifdef STREAM_MUX_GRANT_CNT_EN
    ,
    output logic [CH*16-1:0]      grant_cnt
`endif
);

    // Handshake: a word moves on a rising edge when valid and ready are both high on that
    // interface; ready never waits on the same channel's valid beyond the grant decision.
    localparam int NPAD = 1 << SEL_W;

    logic                 load;
    logic                 grant_valid;
    logic [SEL_W-1:0]     grant;
    logic [SEL_W-1:0]     rr_grant;
    logic [SEL_W-1:0]     ptr;
    logic [NPAD-1:0]      valid_pad;
    logic [2*CH-1:0]      valid_dbl;
    logic [CH-1:0]        valid_rot;
    logic [WIDTH-1:0]     grant_data;
    int                   idx;

    assign load = ~dout_valid | dout_ready;

    always_comb begin
        // Zero padding makes an out-of-range sel read as "not valid".
        valid_pad            = '0;
        valid_pad[CH-1:0]    = din_valid;

        // Rotate so bit 0 is channel ptr+1; the lowest set bit is the round-robin winner.
        valid_dbl = {din_valid, din_valid} >> ({1'b0, ptr} + 1'b1);
        valid_rot = valid_dbl[CH-1:0];
        rr_grant  = ptr;
        idx       = 0;
        for (int k = CH - 1; k >= 0; k--) begin
            if (valid_rot[k]) begin
                idx = int'(ptr) + 1 + k;
                if (idx >= CH) idx = idx - CH;
                rr_grant = SEL_W'(idx);
            end
        end

        if (mode) begin
            grant       = rr_grant;
            grant_valid = |din_valid;
        end else begin
            grant       = sel;
            grant_valid = valid_pad[sel];
        end

        grant_data = '0;
        for (int i = 0; i < CH; i++) begin
            if (grant == SEL_W'(i)) grant_data = din[i*WIDTH +: WIDTH];
        end

        for (int i = 0; i < CH; i++) begin
            din_ready[i] = load & grant_valid & (grant == SEL_W'(i));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout       <= '0;
            dout_valid <= 1'b0;
            dout_ch    <= '0;
            ptr        <= SEL_W'(CH - 1);
        end else if (load) begin
            if (grant_valid) begin
                dout       <= grant_data;
                dout_ch    <= grant;
                dout_valid <= 1'b1;
                if (mode) ptr <= grant;
            end else begin
                dout_valid <= 1'b0;
            end
        end
    end

`ifdef STREAM_MUX_GRANT_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_cnt <= '0;
        end else begin
            for (int i = 0; i < CH; i++) begin
                if (din_valid[i] && din_ready[i] && grant_cnt[i*16 +: 16] != 16'hFFFF)
                    grant_cnt[i*16 +: 16] <= grant_cnt[i*16 +: 16] + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_stream_mux_rr.sv
// Scoreboard bench for stream_mux_rr: a driver feeds a queue-based reference model, a monitor
// pops expected {channel, data} words whenever the output handshake completes.
module tb_stream_mux_rr;

  localparam int WIDTH = 4;
  localparam int CH    = 4;
  localparam int SEL_W = 2;
  localparam int W     = SEL_W + WIDTH;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [CH*WIDTH-1:0] din;
  logic [CH-1:0]       din_valid;
  logic [CH-1:0]       din_ready;
  logic                mode;
  logic [SEL_W-1:0]    sel;
  logic [WIDTH-1:0]    dout;
  logic                dout_valid;
  logic [SEL_W-1:0]    dout_ch;
  logic                dout_ready;
`ifdef STREAM_MUX_GRANT_CNT_EN
  logic [CH*16-1:0]    grant_cnt;
`endif

  stream_mux_rr #(.WIDTH(WIDTH), .CH(CH), .SEL_W(SEL_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .din        (din),
    .din_valid  (din_valid),
    .din_ready  (din_ready),
    .mode       (mode),
    .sel        (sel),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ch    (dout_ch),
    .dout_ready (dout_ready)
`ifdef STREAM_MUX_GRANT_CNT_EN
    ,
    .grant_cnt  (grant_cnt)
`endif
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  logic [W-1:0] exp_q[$];

  // reference model state: last round-robin winner, output-register occupancy, accept counts
  int m_last;
  bit m_occ;
  int m_cnt[CH];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_last = CH - 1;
    m_occ  = 1'b0;
    exp_q.delete();
  endtask

  // driver: one cycle of stimulus, checked against the model, expected output queued
  task automatic drive_cycle(input logic [CH*WIDTH-1:0] d, input logic [CH-1:0] v,
                             input bit m, input int s, input bit r);
    int g;
    int c;
    bit gv;
    bit ld;
    logic [CH-1:0] exp_rdy;
    @(negedge clk);
    din        = d;
    din_valid  = v;
    mode       = m;
    sel        = SEL_W'(s);
    dout_ready = r;
    #1;
    check("dout_valid", 64'(dout_valid), 64'(m_occ));
    ld = !m_occ || r;
    gv = 1'b0;
    g  = 0;
    if (!m) begin
      if (s < CH && v[s]) begin
        gv = 1'b1;
        g  = s;
      end
    end else begin
      for (int k = 1; k <= CH; k++) begin
        c = (m_last + k) % CH;
        if (!gv && v[c]) begin
          gv = 1'b1;
          g  = c;
        end
      end
    end
    exp_rdy = (ld && gv) ? (CH'(1) << g) : '0;
    check("din_ready", 64'(din_ready), 64'(exp_rdy));
    if (ld) begin
      if (gv) begin
        exp_q.push_back({SEL_W'(g), d[g*WIDTH +: WIDTH]});
        m_occ = 1'b1;
        if (m) m_last = g;
        if (m_cnt[g] < 16'hFFFF) m_cnt[g]++;
      end else begin
        m_occ = 1'b0;
      end
    end
  endtask

  // monitor: compares every completed output handshake and output stability under stall
  initial begin : monitor
    logic [W-1:0] exp_w;
    logic [W-1:0] prev;
    bit hold;
    hold = 1'b0;
    prev = '0;
    forever begin
      @(negedge clk);
      #2;
      if (rst_n === 1'b1) begin
        if (hold) check("stall_stable", 64'({dout_valid, dout_ch, dout}), 64'({1'b1, prev}));
        if (dout_valid && dout_ready) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_output: got ch=%0d data=%0h expected nothing", dout_ch, dout);
          end else begin
            exp_w = exp_q.pop_front();
            check("dout_word", 64'({dout_ch, dout}), 64'(exp_w));
          end
        end
        hold = dout_valid && !dout_ready;
        prev = {dout_ch, dout};
      end else begin
        hold = 1'b0;
      end
    end
  end

  initial begin : main
    logic [CH*WIDTH-1:0] seq_data;
    bit rmode;
    for (int i = 0; i < CH; i++) m_cnt[i] = 0;
    model_reset();
    rst_n      = 1'b0;
    din        = '0;
    din_valid  = '0;
    mode       = 1'b0;
    sel        = '0;
    dout_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_dout", 64'(dout), 64'(0));
    check("reset_dout_valid", 64'(dout_valid), 64'(0));
    check("reset_dout_ch", 64'(dout_ch), 64'(0));
    rst_n = 1'b1;

    // round-robin fairness from reset: ch i carries i+1
    seq_data = {4'h4, 4'h3, 4'h2, 4'h1};
    repeat (8) drive_cycle(seq_data, 4'b1111, 1'b1, 0, 1'b1);

    // fixed mode, sel=2, all channels valid
    repeat (3) drive_cycle({4'h7, 4'hA, 4'h5, 4'h6}, 4'b1111, 1'b0, 2, 1'b1);

    // backpressure: hold 3 cycles then resume with no bubble
    drive_cycle({4'h9, 4'h8, 4'h7, 4'h6}, 4'b1111, 1'b1, 0, 1'b1);
    repeat (3) drive_cycle({4'hC, 4'hB, 4'hE, 4'hD}, 4'b1111, 1'b1, 0, 1'b0);
    repeat (2) drive_cycle({4'h1, 4'h2, 4'h3, 4'h4}, 4'b1111, 1'b1, 0, 1'b1);

    // sparse request wrap: ptr -> 2, then only ch1, then ch0+ch3
    drive_cycle({4'h0, 4'h5, 4'h0, 4'h0}, 4'b0100, 1'b1, 0, 1'b1);
    drive_cycle({4'h0, 4'h0, 4'h6, 4'h0}, 4'b0010, 1'b1, 0, 1'b1);
    repeat (2) drive_cycle({4'h3, 4'h0, 4'h0, 4'hF}, 4'b1001, 1'b1, 0, 1'b1);

    // randomized traffic with occasional mode switches
    rmode = 1'b1;
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 15) == 0) rmode = ~rmode;
      drive_cycle(CH*WIDTH'($urandom), CH'($urandom_range(0, 15)), rmode,
                  $urandom_range(0, CH - 1), $urandom_range(0, 3) != 0);
    end

    // reset with a buffered word: build a stalled full register first
    drive_cycle({4'h2, 4'h2, 4'h2, 4'h2}, 4'b1111, 1'b0, 1, 1'b0);
    drive_cycle({4'h2, 4'h2, 4'h2, 4'h2}, 4'b1111, 1'b0, 1, 1'b0);
    @(negedge clk);
    check("pre_reset_full", 64'(dout_valid), 64'(1));
    rst_n     = 1'b0;
    din_valid = '0;
    #1;
    check("midreset_dout", 64'(dout), 64'(0));
    check("midreset_dout_valid", 64'(dout_valid), 64'(0));
    check("midreset_dout_ch", 64'(dout_ch), 64'(0));
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) drive_cycle(seq_data, 4'b1111, 1'b1, 0, 1'b1);

`ifdef STREAM_MUX_GRANT_CNT_EN
    for (int n = 0; n < 65540; n++) drive_cycle(seq_data, 4'b1000, 1'b0, 3, 1'b1);
`endif

    // drain
    repeat (4) drive_cycle('0, '0, 1'b1, 0, 1'b1);
    check("queue_drained", 64'(exp_q.size()), 64'(0));

`ifdef STREAM_MUX_GRANT_CNT_EN
    for (int i = 0; i < CH; i++) check("grant_cnt", 64'(grant_cnt[i*16 +: 16]), 64'(m_cnt[i]));
    check("grant_cnt_sat_ch3", 64'(grant_cnt[63:48]), 64'(16'hFFFF));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/stream_mux_rr.md
Name: stream_mux_rr

Overview:
- Parametrised successor to the team's 4:1 combinational 4-bit selector.
- Selects one of CH input streams, each WIDTH bits with valid/ready, onto a single registered output stream.
- Two modes:
  - fixed: channel chosen by the sel input.
  - round-robin: fair arbitration across all requesting channels.
- Sits between per-channel data sources and a shared downstream consumer. Sustains one transfer per cycle.

Parameters:
- WIDTH, 4, data width per channel.
- CH, 4, number of input channels; legal range 2..16.
- SEL_W, 2, width of sel/dout_ch; must equal ceil(log2(CH)).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- din  input  CH*WIDTH  packed channel data; channel i occupies bits [i*WIDTH +: WIDTH].
- din_valid  input  CH  per-channel valid.
- din_ready  output  CH  per-channel ready; combinational.
- mode  input  1  0 = fixed select, 1 = round-robin.
- sel  input  SEL_W  channel index used in fixed mode.
- dout  output  WIDTH  registered output data.
- dout_valid  output  1  registered output valid.
- dout_ch  output  SEL_W  index of the channel that produced dout.
- dout_ready  input  1  downstream ready.

Behaviour:
- Clock and reset: single clock, clk; reset rst_n is asynchronous, active-low.
- Reset values: dout = 0, dout_valid = 0, dout_ch = 0, round-robin pointer ptr = CH-1, so channel 0 has first priority.
- Output register:
  - load = ~dout_valid | dout_ready.
  - The register can accept a new word when it is empty, or when it is being drained in the same cycle. This gives full throughput with no bubble.
- Grant, computed combinationally every cycle:
  - Fixed mode: grant_valid = din_valid[sel] and sel < CH; grant = sel.
  - Round-robin mode: grant is the first i with din_valid[i] set, searching from ptr+1 upward and wrapping CH-1 to 0; ptr itself is searched last. grant_valid = |din_valid.
- din_ready[i] = load & grant_valid & (grant == i). At most one bit is set.
  - din_ready does not depend on din_valid of the granted channel beyond the grant logic.
  - A source may hold valid indefinitely.
- On a clock edge with load = 1:
  - If grant_valid: dout <= din[grant], dout_ch <= grant, dout_valid <= 1, and, in round-robin mode only, ptr <= grant.
  - Else: dout_valid <= 0; dout and dout_ch hold their previous values.
- On a clock edge with load = 0: dout, dout_ch, dout_valid and ptr all hold (backpressure). Input data is not captured.
- Latency: the input transfer at edge N makes the word visible on dout after edge N, i.e. one cycle.
- Fixed mode never modifies ptr. Switching mode takes effect on the next grant evaluation with no flush. A word already in the output register is unaffected.
- sel >= CH (CH not a power of two): no grant, din_ready all 0, dout_valid drains to 0.
- Stability: dout, dout_ch and dout_valid must stay stable while dout_valid = 1 and dout_ready = 0.
- Reset mid-transfer: the register and ptr return to reset values asynchronously; a buffered word is discarded.
- Arbitration fairness: with all CH channels continuously valid in round-robin mode, grants cycle 0,1,...,CH-1,0,... with no repeats.

Optional Feature:
- Macro: STREAM_MUX_GRANT_CNT_EN.
- Defined:
  - Adds output port grant_cnt, width CH*16: per-channel count of accepted input transfers (din_valid[i] & din_ready[i]).
  - Each counter saturates at 16'hFFFF and is reset to 0 by rst_n.
- Undefined: port and counters are absent. All other behaviour is identical.

Test Plan:
- Reset: assert rst_n=0 mid-run with dout_valid=1 -> dout=0, dout_valid=0, dout_ch=0 immediately; after release, CH=4 round-robin with all valid -> first grant is channel 0.
- Fixed mode: sel=2, din ch2=4'hA valid, dout_ready=1 -> din_ready=4'b0100; next cycle dout=4'hA, dout_ch=2, dout_valid=1; ch0/1/3 valid but never readied.
- Round-robin fairness: all four valid, data ch i = i+1, dout_ready=1 for 8 cycles -> dout_ch sequence 0,1,2,3,0,1,2,3; dout 1,2,3,4,1,2,3,4.
- Backpressure: dout_valid=1, dout_ready=0 for 3 cycles -> din_ready=0, dout/dout_ch stable; on dout_ready=1, the new word is loaded in the same cycle with no bubble.
- Sparse request wrap: ptr=2, only ch1 valid -> grant 1; then ch0 and ch3 valid -> grant 3, then 0.
- Macro on: 5 transfers from ch3 -> grant_cnt[63:48]=5; counter preloaded near max via 0xFFFF+2 transfers -> holds at 16'hFFFF.
